// File: rtl/mem8x8_host.sv
// Bus master for the mem8x8 sel/op/valid interface: one client request per access.
// Define MEM8X8_HOST_TIMEOUT_EN to abort accesses the memory never answers (rsp_err).
module mem8x8_host #(
    parameter int ADDR_W         = 3,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_sel,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic [1:0]        dbg_state,
    output logic              dbg_bus_oe
);

    // Client handshake: a request transfers on the rising edge where
    // req_valid=1 and req_ready=1; req_ready is 1 exactly while the host is idle.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] wdata_q;
    logic              bus_oe_q;
    logic              accept;
    logic              tmo_reached;
    logic              timeout_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign accept     = (state_q == S_IDLE) && req_valid;
    assign mem_data   = bus_oe_q ? wdata_q : 'z;
    assign dbg_state  = state_q;
    assign dbg_bus_oe = bus_oe_q;

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // A memory answer on the timeout edge still counts as success.
                if (mem_valid) begin
                    state_d = S_DONE;
                end else if (tmo_reached) begin
                    state_d     = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // A lingering valid must not complete the next access.
                if (!mem_valid) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_sel   <= 1'b0;
            mem_op    <= 1'b0;
            mem_addr  <= '0;
            wdata_q   <= '0;
            bus_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ready <= (state_d == S_IDLE);
            mem_sel   <= (state_d == S_ACCESS);
            rsp_valid <= (state_d == S_DONE);
            if (accept) begin
                mem_op   <= req_write;
                mem_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
            // Drive enable follows the next state so it drops together with mem_sel.
            bus_oe_q <= (state_d == S_ACCESS) && (accept ? req_write : mem_op);
            if (state_q == S_ACCESS && mem_valid && !mem_op) begin
                rsp_rdata <= mem_data;
            end else if (timeout_hit) begin
                rsp_rdata <= '0;
            end
        end
    end

`ifdef MEM8X8_HOST_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign tmo_reached = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt <= '0;
            end else if (state_q == S_ACCESS) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            rsp_err <= timeout_hit;
        end
    end
`else
    assign tmo_reached = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem8x8_host.sv
// Self-checking bench for mem8x8_host: behavioural memory plus response scoreboard.
module tb_mem8x8_host;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_sel;
    logic          mem_op;
    logic [AW-1:0] mem_addr;
    logic          mem_valid;
    wire  [DW-1:0] mem_data;
    logic [1:0]    dbg_state;
    logic          dbg_bus_oe;

    // Memory model controls
    logic          mv_r = 1'b0;
    int            hold_cnt = 0;
    logic          mem_en;
    int            extra_hold;
    logic          stray_valid;
    logic [DW-1:0] mem_model [8];
    wire           tb_drive;

    // Scoreboard: {err, rdata} per accepted request
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] exp_mem [8];
    logic [DW-1:0] last_rdata;
    logic [DW:0]   mon_e;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_rsp = 0;

    always #5 clk = ~clk;

    mem8x8_host dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_sel    (mem_sel),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .dbg_state  (dbg_state),
        .dbg_bus_oe (dbg_bus_oe)
    );

    // Memory answers one cycle after sel, optionally holding valid longer.
    assign mem_valid = mv_r | stray_valid;
    assign tb_drive  = mem_sel & ~mem_op & mem_valid;
    assign mem_data  = tb_drive ? mem_model[mem_addr] : 'z;

    always @(posedge clk) begin
        if (mem_sel && mem_en) begin
            mv_r     <= 1'b1;
            hold_cnt <= extra_hold;
        end else if (mv_r && hold_cnt > 0) begin
            hold_cnt <= hold_cnt - 1;
        end else begin
            mv_r <= 1'b0;
        end
        if (mem_sel && mem_valid && mem_op) mem_model[mem_addr] <= mem_data;
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1) begin
            n_rsp++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== mon_e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                             rsp_err, rsp_rdata, mon_e[DW], mon_e[DW-1:0]);
                end
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL send_wait: req_ready=%b, required 1 within 200 cycles", req_ready);
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        if (w) begin
            exp_q.push_back({1'b0, last_rdata});
            exp_mem[a] = d;
        end else begin
            exp_q.push_back({1'b0, exp_mem[a]});
            last_rdata = exp_mem[a];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        int t = 0;
        req_valid = 1'b0;
        while ((exp_q.size() != 0 || req_ready !== 1'b1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 300) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, req_ready=%b, required 0 and 1", exp_q.size(), req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, mem_sel, mem_op, dbg_bus_oe} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: ready,rv,err,sel,op,oe=%b, required 100000",
                     {req_ready, rsp_valid, rsp_err, mem_sel, mem_op, dbg_bus_oe});
        end
        n_cmp++;
        if (rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, required 00", rsp_rdata);
        end
        n_cmp++;
        if (mem_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d, required 0", mem_addr);
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 8'hA5;
        exp_q.push_back({1'b0, last_rdata});
        exp_mem[5] = 8'hA5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_sel, mem_op, dbg_bus_oe, req_ready} !== 4'b1110 || mem_addr !== 3'd5 || mem_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_cycle1: sel,op,oe,ready=%b addr=%0d bus=%h, required 1110 addr=5 bus=a5",
                     {mem_sel, mem_op, dbg_bus_oe, req_ready}, mem_addr, mem_data);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_sel !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_cycle2: sel=%b rsp_valid=%b, required 1 0", mem_sel, rsp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_err, mem_sel, dbg_bus_oe} !== 4'b1000) begin
            n_fail++;
            $display("FAIL wr_cycle3: rv,err,sel,oe=%b, required 1000", {rsp_valid, rsp_err, mem_sel, dbg_bus_oe});
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || dbg_bus_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_cycle4: rsp_valid=%b oe=%b, required 0 0", rsp_valid, dbg_bus_oe);
        end
        drain_all();
        n_cmp++;
        if (mem_model[5] !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_stored: memory holds %h, required a5", mem_model[5]);
        end
    endtask

    task automatic test_read();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5;
        exp_q.push_back({1'b0, 8'hA5});
        last_rdata = 8'hA5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_sel, mem_op, dbg_bus_oe} !== 3'b100 || mem_addr !== 3'd5) begin
            n_fail++;
            $display("FAIL rd_cycle1: sel,op,oe=%b addr=%0d, required 100 addr=5", {mem_sel, mem_op, dbg_bus_oe}, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_cycle3: rsp_valid=%b rdata=%h, required 1 a5", rsp_valid, rsp_rdata);
        end
        drain_all();
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = n_rsp;
        for (int a = 0; a < 8; a++) send(1'b1, 3'(a), 8'(a * 17));
        drain_all();
        n_cmp++;
        if (n_rsp - n0 != 8) begin
            n_fail++;
            $display("FAIL b2b_writes: got %0d responses, required 8", n_rsp - n0);
        end
        n0 = n_rsp;
        for (int a = 0; a < 8; a++) send(1'b0, 3'(a), 8'h00);
        drain_all();
        n_cmp++;
        if (n_rsp - n0 != 8) begin
            n_fail++;
            $display("FAIL b2b_reads: got %0d responses, required 8", n_rsp - n0);
        end
    endtask

    task automatic test_drain();
        int   n0;
        int   t;
        int   g;
        logic prev_v;
        n0 = n_rsp;
        extra_hold = 3;
        send(1'b1, 3'd2, 8'h3C);
        // Second request queued immediately with req_valid held high
        req_write = 1'b0;
        exp_q.push_back({1'b0, 8'h3C});
        last_rdata = 8'h3C;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (rsp_valid !== 1'b1 && t < 40);
        g = 0;
        prev_v = mem_valid;
        do begin
            @(negedge clk);
            g++;
            if (mem_sel !== 1'b1) prev_v = mem_valid;
        end while (mem_sel !== 1'b1 && g < 40);
        n_cmp++;
        if (prev_v !== 1'b0 || g != 6) begin
            n_fail++;
            $display("FAIL drain_gap: next sel after %0d cycles, prior valid=%b, required 6 cycles and 0", g, prev_v);
        end
        drain_all();
        extra_hold = 0;
        n_cmp++;
        if (n_rsp - n0 != 2) begin
            n_fail++;
            $display("FAIL drain_count: got %0d responses, required 2", n_rsp - n0);
        end
    endtask

    task automatic test_idle_valid();
        int bad = 0;
        stray_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_sel !== 1'b0 || req_ready !== 1'b1 || dbg_state !== ST_IDLE) bad++;
        end
        stray_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_valid: %0d cycles left idle, required 0", bad);
        end
        send(1'b0, 3'd3, 8'h00);
        drain_all();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd6; req_wdata = 8'hC3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_sel !== 1'b1 || dbg_bus_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_access: sel=%b oe=%b, required 1 1", mem_sel, dbg_bus_oe);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rdata = 8'h00;
        @(negedge clk);
        n_cmp++;
        if ({mem_sel, dbg_bus_oe, req_ready, rsp_valid} !== 4'b0010 || dbg_state !== ST_IDLE || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_state: sel,oe,ready,rv=%b state=%0d rdata=%h, required 0010 state=0 rdata=00",
                     {mem_sel, dbg_bus_oe, req_ready, rsp_valid}, dbg_state, rsp_rdata);
        end
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_sel !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: %0d cycles with activity, required 0", bad);
        end
        send(1'b0, 3'd6, 8'h00);
        drain_all();
    endtask

    task automatic test_timeout();
        int t = 0;
        int s = 0;
        mem_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4;
`ifdef MEM8X8_HOST_TIMEOUT_EN
        exp_q.push_back({1'b1, 8'h00});
        last_rdata = 8'h00;
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            t++;
            if (mem_sel === 1'b1) s++;
        end while (rsp_valid !== 1'b1 && t < 60);
        n_cmp++;
        if (t != 16 || s != 15) begin
            n_fail++;
            $display("FAIL timeout_len: rsp at cycle %0d after %0d sel cycles, required 16 and 15", t, s);
        end
        mem_en = 1'b1;
        drain_all();
`else
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (mem_sel !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || dbg_state !== ST_ACCESS) t++;
        end
        n_cmp++;
        if (t != 0) begin
            n_fail++;
            $display("FAIL no_timeout: %0d of 100 cycles left ACCESS, required 0", t);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rdata = 8'h00;
        mem_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== ST_IDLE || mem_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_recover: state=%0d sel=%b, required 0 0", dbg_state, mem_sel);
        end
`endif
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        mem_en      = 1'b1;
        extra_hold  = 0;
        stray_valid = 1'b0;
        last_rdata  = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_drain();
        test_idle_valid();
        test_reset_mid();
        test_timeout();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expected responses never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
